// File: rtl/mem_access_ctrl.sv
// +----------------------------------------------------------------------------+
// | mem_access_ctrl: MEM-stage initiator for a negedge-clocked single-port RAM, |
// | with valid/ready request/response channels and saturating access counters. |
// | Optional feature macro: MEM_ACCESS_WRITE_ACK_EN (stores also respond).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              rd_pending;
  logic              rd_pending_blocks;
  logic              accept;
  logic              capture;
  logic              issue_resp;
  logic [DATA_W-1:0] capture_data;

  // A held, unconsumed response stalls the capture; the address register holds
  // meanwhile, so the memory keeps re-reading the same word until it is taken.
  assign rd_pending_blocks = rd_pending && resp_valid && !resp_ready;
  assign req_ready         = !rd_pending_blocks && (!resp_valid || resp_ready);
  assign accept            = req_valid && req_ready;
  assign capture           = rd_pending && !rd_pending_blocks;

`ifdef MEM_ACCESS_WRITE_ACK_EN
  logic pend_is_wr;

  assign issue_resp   = 1'b1;
  assign capture_data = pend_is_wr ? mem_write_data : mem_read_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_is_wr <= 1'b0;
    end else if (accept) begin
      pend_is_wr <= req_we;
    end
  end
`else
  assign issue_resp   = !req_we;
  assign capture_data = mem_read_data;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_address    <= '0;
      mem_we         <= 1'b0;
      mem_write_data <= '0;
      rd_pending     <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      rd_count       <= '0;
      wr_count       <= '0;
    end else begin
      if (accept) begin
        mem_address    <= req_addr;
        mem_we         <= req_we;
        mem_write_data <= req_wdata;
        if (req_we) begin
          if (wr_count != CNT_MAX) wr_count <= wr_count + CNT_ONE;
        end else begin
          if (rd_count != CNT_MAX) rd_count <= rd_count + CNT_ONE;
        end
      end else begin
        mem_we <= 1'b0;
      end

      if (accept) begin
        rd_pending <= issue_resp;
      end else if (capture) begin
        rd_pending <= 1'b0;
      end

      if (capture) begin
        resp_rdata <= capture_data;
        resp_valid <= 1'b1;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed steps plus randomized traffic
// against a negedge RAM and a queue/array reference model.
`default_nettype none

module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_rdata;
  logic [7:0]  mem_address;
  logic        mem_we;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data = '0;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_we(mem_we), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  // Negedge single-port RAM; a write is visible to the read of the same edge.
  logic [15:0] mem [0:255];
  always @(negedge clock) begin
    if (mem_we) mem[mem_address] <= mem_write_data;
    mem_read_data <= mem_we ? mem_write_data : mem[mem_address];
  end

  // Reference model: memory contents in request order, expected responses, counts.
  logic [15:0] model_mem [0:255];
  logic [15:0] exp_q[$];
  int          m_rd = 0;
  int          m_wr = 0;
  logic        held = 1'b0;
  logic [15:0] held_data = '0;
  int          nresp_wait = 0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rd = 0;
    m_wr = 0;
    held = 1'b0;
    nresp_wait = 0;
  endtask

  // One cycle: drive after posedge, evaluate the coming edge's handshakes mid-cycle.
  task automatic step(input logic v, input logic we, input logic [7:0] a,
                      input logic [15:0] d, input logic rr);
    @(posedge clock);
    #1;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; resp_ready = rr;
    @(negedge clock);
    #1;
    check("rd_count", {16'h0, rd_count}, m_rd);
    check("wr_count", {16'h0, wr_count}, m_wr);
    check("req_ready", {31'h0, req_ready}, {31'h0, !(resp_valid && !rr)});
    if (held) begin
      check("held_valid", {31'h0, resp_valid}, 32'h1);
      check("held_rdata", {16'h0, resp_rdata}, {16'h0, held_data});
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'h0, resp_valid}, 32'h0);
      end else begin
        check("resp_rdata", {16'h0, resp_rdata}, {16'h0, exp_q[0]});
        if (rr) void'(exp_q.pop_front());
      end
    end
    if (exp_q.size() > 0 && !resp_valid) nresp_wait++;
    else nresp_wait = 0;
    check("resp_latency", {31'h0, nresp_wait <= 1}, 32'h1);
    held = resp_valid && !rr;
    held_data = resp_rdata;
    if (v && req_ready) begin
      if (we) begin
        model_mem[a] = d;
        if (m_wr < 16'hFFFF) m_wr++;
`ifdef MEM_ACCESS_WRITE_ACK_EN
        exp_q.push_back(d);
`endif
      end else begin
        exp_q.push_back(model_mem[a]);
        if (m_rd < 16'hFFFF) m_rd++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 16'(i * 16'h0101) ^ 16'hA5A5;
      model_mem[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
    end

    // Reset state
    #12;
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_address", {24'h0, mem_address}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", {16'h0, resp_rdata}, 32'h0);
    check("rst_counts", {rd_count, wr_count}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_rst", {31'h0, req_ready}, 32'h1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);

    // Reset raised after a store is accepted but before its negedge write
    @(posedge clock); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h03; req_wdata = 16'h7777;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("store_issued", {31'h0, mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_mem_we", {31'h0, mem_we}, 32'h0);
    check("midrst_mem_address", {24'h0, mem_address}, 32'h0);
    check("midrst_wdata", {16'h0, mem_write_data}, 32'h0);
    check("midrst_resp", {15'h0, resp_valid, resp_rdata}, 32'h0);
    check("midrst_counts", {rd_count, wr_count}, 32'h0);
    @(negedge clock); #1;
    check("midrst_mem_word", {16'h0, mem[3]}, {16'h0, model_mem[3]});
    #1;
    reset = 1'b0;
    #1;
    check("midrst_ready", {31'h0, req_ready}, 32'h1);
    model_reset();

    // Store then load to the same address on consecutive cycles
    step(1'b1, 1'b1, 8'h05, 16'h1234, 1'b1);
    step(1'b1, 1'b0, 8'h05, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    check("st_ld_valid", {31'h0, resp_valid}, 32'h1);
    check("st_ld_rdata", {16'h0, resp_rdata}, 32'h1234);
    check("st_ld_counts", {rd_count, wr_count}, 32'h0001_0001);

    // Three back-to-back loads consumed immediately
    step(1'b1, 1'b0, 8'h00, 16'h0, 1'b1);
    check("b2b_ready0", {31'h0, req_ready}, 32'h1);
    step(1'b1, 1'b0, 8'h01, 16'h0, 1'b1);
    check("b2b_ready1", {31'h0, req_ready}, 32'h1);
    step(1'b1, 1'b0, 8'hFF, 16'h0, 1'b1);
    check("b2b_ready2", {31'h0, req_ready}, 32'h1);
    check("b2b_resp0", {15'h0, resp_valid, resp_rdata}, {15'h0, 1'b1, model_mem[0]});
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    check("b2b_resp1", {15'h0, resp_valid, resp_rdata}, {15'h0, 1'b1, model_mem[1]});
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    check("b2b_resp2", {15'h0, resp_valid, resp_rdata}, {15'h0, 1'b1, model_mem[255]});
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    check("b2b_drained", {31'h0, resp_valid}, 32'h0);

    // Backpressure for three cycles, then immediate acceptance
    step(1'b1, 1'b0, 8'h07, 16'h0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h09, 16'hDEAD, 1'b0);
      check("bp_valid", {31'h0, resp_valid}, 32'h1);
      check("bp_rdata", {16'h0, resp_rdata}, {16'h0, model_mem[7]});
      check("bp_ready", {31'h0, req_ready}, 32'h0);
      check("bp_mem_we", {31'h0, mem_we}, 32'h0);
    end
    step(1'b1, 1'b0, 8'h08, 16'h0, 1'b1);
    check("bp_release_ready", {31'h0, req_ready}, 32'h1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);

    // Store response behaviour
    step(1'b1, 1'b1, 8'h40, 16'hBEEF, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
`ifdef MEM_ACCESS_WRITE_ACK_EN
    check("wack_resp", {15'h0, resp_valid, resp_rdata}, {15'h0, 1'b1, 16'hBEEF});
`else
    check("wack_none", {31'h0, resp_valid}, 32'h0);
`endif
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    check("wack_done", {31'h0, resp_valid}, 32'h0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    check("queue_drained", exp_q.size(), 32'h0);

    // Drive the store counter to saturation
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 16'hFFFE + 3; i++) begin
      step(1'b1, 1'b1, 8'($urandom_range(128, 255)), 16'($urandom), 1'b1);
    end
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 16'h0, 1'b1);
    check("wr_count_sat", {16'h0, wr_count}, 32'hFFFF);
    check("rd_count_zero", {16'h0, rd_count}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
